// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer. Runs one memory instruction from EX/MEM as
// a cache handshake (word, byte and two-access indirect forms), stalls the
// upstream pipeline while the access is outstanding, then presents the load
// result and pulses the MEM_WB load enable for one cycle.
module mem_access_ctrl #(
  parameter int DATA_W = 16,
  parameter int OPC_W  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid_in,
  input  logic [OPC_W-1:0]  opcode_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic [DATA_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_resp,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [1:0]        dmem_byte_en,
  output logic [DATA_W-1:0] mem_rdata_out,
  output logic              load_memwb,
  output logic              stall_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_IND  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [OPC_W-1:0] OP_LDB = OPC_W'(4'b0010);
  localparam logic [OPC_W-1:0] OP_STB = OPC_W'(4'b0011);
  localparam logic [OPC_W-1:0] OP_LDI = OPC_W'(4'b1010);
  localparam logic [OPC_W-1:0] OP_STI = OPC_W'(4'b1011);

  logic [1:0]        state_q, state_d;
  logic [OPC_W-1:0]  opc_q, opc_d;
  logic              store_q, store_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              memop;
  logic              start;
  logic              is_ind;
  logic              is_byte;
  logic [7:0]        sel_byte;
  logic [DATA_W-1:0] byte_sext;

  assign memop   = mem_read_in | mem_write_in;
  assign start   = valid_in & memop;
  assign is_ind  = (opc_q == OP_LDI) || (opc_q == OP_STI);
  assign is_byte = (opc_q == OP_LDB) || (opc_q == OP_STB);

  // Byte load: odd address picks the high byte, result is sign-extended.
  assign sel_byte  = addr_q[0] ? dmem_rdata[15:8] : dmem_rdata[7:0];
  assign byte_sext = {{(DATA_W-8){sel_byte[7]}}, sel_byte};

  // Sequencer next state; the instruction is captured on entry to ACC so the
  // request stays stable even if valid_in or the EX/MEM fields change.
  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    store_d = store_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ptr_d   = ptr_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACC;
          opc_d   = opcode_in;
          store_d = mem_write_in;
          addr_d  = addr_in;
          wdata_d = wdata_in;
        end
      end
      S_ACC: begin
        if (dmem_resp) begin
          if (is_ind) begin
            ptr_d   = dmem_rdata;
            state_d = S_IND;
          end else begin
            if (!store_q) rdata_d = is_byte ? byte_sext : dmem_rdata;
            state_d = S_DONE;
          end
        end
      end
      S_IND: begin
        if (dmem_resp) begin
          if (!store_q) rdata_d = dmem_rdata;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any outstanding access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      opc_q   <= '0;
      store_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ptr_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      store_q <= store_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ptr_q   <= ptr_d;
      rdata_q <= rdata_d;
    end
  end

  // Cache request and pipeline handshake outputs, decoded from the state.
  always_comb begin
    dmem_read    = 1'b0;
    dmem_write   = 1'b0;
    dmem_addr    = '0;
    dmem_wdata   = '0;
    dmem_byte_en = 2'b00;
    load_memwb   = 1'b0;
    stall_out    = 1'b0;
    case (state_q)
      S_IDLE: begin
        load_memwb = valid_in & ~memop;
        // Reset holds stall low even though the FSM already reads IDLE.
        stall_out  = start & reset_n;
      end
      S_ACC: begin
        stall_out    = 1'b1;
        dmem_addr    = {addr_q[DATA_W-1:1], 1'b0};
        // Indirect forms fetch the pointer first, even for STI.
        dmem_read    = ~store_q | is_ind;
        dmem_write   = store_q & ~is_ind;
        dmem_byte_en = (is_byte && store_q) ? (addr_q[0] ? 2'b10 : 2'b01) : 2'b11;
        if (store_q && !is_ind)
          dmem_wdata = is_byte ? {(DATA_W/8){wdata_q[7:0]}} : wdata_q;
      end
      S_IND: begin
        stall_out    = 1'b1;
        dmem_addr    = {ptr_q[DATA_W-1:1], 1'b0};
        dmem_read    = ~store_q;
        dmem_write   = store_q;
        dmem_byte_en = 2'b11;
        if (store_q) dmem_wdata = wdata_q;
      end
      default: begin
        load_memwb = 1'b1;
      end
    endcase
  end

  assign mem_rdata_out = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: table of memory transactions with
// hand-computed cache traffic and results, plus hand-written corner sequences.
module tb_mem_access_ctrl;

  logic        clk;
  logic        reset_n;
  logic        valid_in;
  logic [3:0]  opcode_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [15:0] addr_in;
  logic [15:0] wdata_in;
  logic [15:0] dmem_rdata;
  logic        dmem_resp;
  logic        dmem_read;
  logic        dmem_write;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic [1:0]  dmem_byte_en;
  logic [15:0] mem_rdata_out;
  logic        load_memwb;
  logic        stall_out;

  int n_cmp = 0;
  int n_err = 0;

  mem_access_ctrl #(.DATA_W(16), .OPC_W(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .valid_in     (valid_in),
    .opcode_in    (opcode_in),
    .mem_read_in  (mem_read_in),
    .mem_write_in (mem_write_in),
    .addr_in      (addr_in),
    .wdata_in     (wdata_in),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_byte_en (dmem_byte_en),
    .mem_rdata_out(mem_rdata_out),
    .load_memwb   (load_memwb),
    .stall_out    (stall_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One transaction: inputs, per-access cache latency/data, expected traffic.
  // dir is {read,write}; d2 == 0 means a single access.
  typedef struct packed {
    logic [3:0]  opc;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [3:0]  d1;
    logic [15:0] r1;
    logic [3:0]  d2;
    logic [15:0] r2;
    logic [15:0] a1_addr;
    logic [1:0]  a1_dir;
    logic [1:0]  a1_be;
    logic [15:0] a1_wd;
    logic [15:0] a2_addr;
    logic [1:0]  a2_dir;
    logic [15:0] a2_wd;
    logic [15:0] exp_rdata;
    logic [3:0]  exp_stall;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int stalls;
    int n;
    string tag;
    tag = $sformatf("v%0d", idx);
    valid_in = 1'b1; opcode_in = v.opc; mem_read_in = v.rd; mem_write_in = v.wr;
    addr_in = v.addr; wdata_in = v.wdata; dmem_resp = 1'b0;
    #1;
    check({tag, "_idle_stall"}, {31'd0, stall_out}, 32'd1);
    check({tag, "_idle_req"}, {30'd0, dmem_read, dmem_write}, 32'd0);
    check({tag, "_idle_load"}, {31'd0, load_memwb}, 32'd0);
    stalls = stall_out ? 1 : 0;
    @(posedge clk);
    for (int acc = 0; acc < 2; acc++) begin
      if (acc == 1 && v.d2 == 0) break;
      n = (acc == 0) ? int'(v.d1) : int'(v.d2);
      for (int c = 1; c <= n; c++) begin
        @(negedge clk);
        dmem_resp = 1'b0;
        #1;
        if (stall_out) stalls++;
        check($sformatf("%s_a%0d_c%0d_req", tag, acc, c), {30'd0, dmem_read, dmem_write},
              {30'd0, (acc == 0) ? v.a1_dir : v.a2_dir});
        check($sformatf("%s_a%0d_c%0d_addr", tag, acc, c), {16'd0, dmem_addr},
              {16'd0, (acc == 0) ? v.a1_addr : v.a2_addr});
        check($sformatf("%s_a%0d_c%0d_be", tag, acc, c), {30'd0, dmem_byte_en},
              {30'd0, (acc == 0) ? v.a1_be : 2'b11});
        if (((acc == 0) ? v.a1_dir : v.a2_dir) == 2'b01)
          check($sformatf("%s_a%0d_c%0d_wdata", tag, acc, c), {16'd0, dmem_wdata},
                {16'd0, (acc == 0) ? v.a1_wd : v.a2_wd});
        if (c == n) begin
          dmem_resp  = 1'b1;
          dmem_rdata = (acc == 0) ? v.r1 : v.r2;
        end
        @(posedge clk);
      end
    end
    @(negedge clk);
    dmem_resp = 1'b0; dmem_rdata = 16'h0;
    #1;
    check({tag, "_stall_cycles"}, stalls, {28'd0, v.exp_stall});
    check({tag, "_done_stall"}, {31'd0, stall_out}, 32'd0);
    check({tag, "_done_load"}, {31'd0, load_memwb}, 32'd1);
    check({tag, "_done_req"}, {30'd0, dmem_read, dmem_write}, 32'd0);
    check({tag, "_rdata"}, {16'd0, mem_rdata_out}, {16'd0, v.exp_rdata});
    valid_in = 1'b0; opcode_in = 4'h0; mem_read_in = 1'b0; mem_write_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check({tag, "_after_load"}, {31'd0, load_memwb}, 32'd0);
    check({tag, "_after_stall"}, {31'd0, stall_out}, 32'd0);
  endtask

  initial begin
    //              opc    rd    wr    addr     wdata    d1    r1       d2    r2       a1addr   dir    be     a1wd     a2addr   dir    a2wd     rdata    stall
    vecs[0] = '{4'h6, 1'b1, 1'b0, 16'h1004, 16'h0000, 4'd3, 16'hBEEF, 4'd0, 16'h0000, 16'h1004, 2'b10, 2'b11, 16'h0000, 16'h0000, 2'b00, 16'h0000, 16'hBEEF, 4'd4};
    vecs[1] = '{4'h2, 1'b1, 1'b0, 16'h2001, 16'h0000, 4'd1, 16'h80AA, 4'd0, 16'h0000, 16'h2000, 2'b10, 2'b11, 16'h0000, 16'h0000, 2'b00, 16'h0000, 16'hFF80, 4'd2};
    vecs[2] = '{4'h2, 1'b1, 1'b0, 16'h2000, 16'h0000, 4'd2, 16'h80AA, 4'd0, 16'h0000, 16'h2000, 2'b10, 2'b11, 16'h0000, 16'h0000, 2'b00, 16'h0000, 16'hFFAA, 4'd3};
    vecs[3] = '{4'h3, 1'b0, 1'b1, 16'h3001, 16'h12CD, 4'd2, 16'hDEAD, 4'd0, 16'h0000, 16'h3000, 2'b01, 2'b10, 16'hCDCD, 16'h0000, 2'b00, 16'h0000, 16'hFFAA, 4'd3};
    vecs[4] = '{4'hA, 1'b1, 1'b0, 16'h4000, 16'h0000, 4'd2, 16'h5002, 4'd3, 16'h1234, 16'h4000, 2'b10, 2'b11, 16'h0000, 16'h5002, 2'b10, 16'h0000, 16'h1234, 4'd6};
    vecs[5] = '{4'hB, 1'b0, 1'b1, 16'h4000, 16'h5A5A, 4'd1, 16'h5002, 4'd2, 16'hDEAD, 16'h4000, 2'b10, 2'b11, 16'h0000, 16'h5002, 2'b01, 16'h5A5A, 16'h1234, 4'd4};
    vecs[6] = '{4'h7, 1'b0, 1'b1, 16'h6003, 16'hA55A, 4'd1, 16'hDEAD, 4'd0, 16'h0000, 16'h6002, 2'b01, 2'b11, 16'hA55A, 16'h0000, 2'b00, 16'h0000, 16'h1234, 4'd2};
    vecs[7] = '{4'h2, 1'b1, 1'b0, 16'h7001, 16'h0000, 4'd1, 16'h7F00, 4'd0, 16'h0000, 16'h7000, 2'b10, 2'b11, 16'h0000, 16'h0000, 2'b00, 16'h0000, 16'h007F, 4'd2};
    vecs[8] = '{4'h6, 1'b1, 1'b0, 16'h8001, 16'h0000, 4'd4, 16'h0123, 4'd0, 16'h0000, 16'h8000, 2'b10, 2'b11, 16'h0000, 16'h0000, 2'b00, 16'h0000, 16'h0123, 4'd5};
    vecs[9] = '{4'h3, 1'b0, 1'b1, 16'h3000, 16'h00AB, 4'd1, 16'hDEAD, 4'd0, 16'h0000, 16'h3000, 2'b01, 2'b01, 16'hABAB, 16'h0000, 2'b00, 16'h0000, 16'h0123, 4'd2};

    reset_n = 1'b0; valid_in = 1'b0; opcode_in = 4'h0; mem_read_in = 1'b0; mem_write_in = 1'b0;
    addr_in = 16'h0; wdata_in = 16'h0; dmem_rdata = 16'h0; dmem_resp = 1'b0;

    // Reset: everything quiet; non-memop still loads MEM_WB; memop must not stall.
    #2;
    check("rst_req", {30'd0, dmem_read, dmem_write}, 32'd0);
    check("rst_addr", {16'd0, dmem_addr}, 32'd0);
    check("rst_be", {30'd0, dmem_byte_en}, 32'd0);
    check("rst_wdata", {16'd0, dmem_wdata}, 32'd0);
    check("rst_rdata", {16'd0, mem_rdata_out}, 32'd0);
    check("rst_load", {31'd0, load_memwb}, 32'd0);
    check("rst_stall", {31'd0, stall_out}, 32'd0);
    valid_in = 1'b1; opcode_in = 4'h1;
    #1;
    check("rst_nonmem_load", {31'd0, load_memwb}, 32'd1);
    mem_read_in = 1'b1; opcode_in = 4'h6;
    #1;
    check("rst_memop_stall", {31'd0, stall_out}, 32'd0);
    valid_in = 1'b0; mem_read_in = 1'b0; opcode_in = 4'h0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Non-memory instruction, with a stray cache response that must be ignored.
    valid_in = 1'b1; opcode_in = 4'h1; dmem_resp = 1'b1; dmem_rdata = 16'h7777;
    #1;
    check("add_load", {31'd0, load_memwb}, 32'd1);
    check("add_stall", {31'd0, stall_out}, 32'd0);
    check("add_req", {30'd0, dmem_read, dmem_write}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    dmem_resp = 1'b0; valid_in = 1'b0; opcode_in = 4'h0;
    #1;
    check("add_rdata_kept", {16'd0, mem_rdata_out}, 32'd0);
    check("add_stays_idle", {29'd0, stall_out, dmem_read, dmem_write}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      run_vec(i, vecs[i]);
      $display("txn %0d opc=%h addr=%h -> rdata_out=%h", i, vecs[i].opc, vecs[i].addr, mem_rdata_out);
    end

    // valid_in drops and EX/MEM fields change mid-access: access still completes.
    valid_in = 1'b1; opcode_in = 4'h6; mem_read_in = 1'b1; addr_in = 16'h9000;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0; mem_read_in = 1'b0; addr_in = 16'hFFFF; opcode_in = 4'h0;
    #1;
    check("vdrop_req", {30'd0, dmem_read, dmem_write}, 32'd2);
    check("vdrop_addr", {16'd0, dmem_addr}, 32'h9000);
    dmem_resp = 1'b1; dmem_rdata = 16'h4321;
    @(posedge clk);
    @(negedge clk);
    dmem_resp = 1'b0;
    #1;
    check("vdrop_load", {31'd0, load_memwb}, 32'd1);
    check("vdrop_rdata", {16'd0, mem_rdata_out}, 32'h4321);
    $display("txn vdrop addr=9000 -> rdata_out=%h", mem_rdata_out);
    @(posedge clk);
    @(negedge clk);

    // Reset asserted during the indirect access drops the request without a clock edge.
    valid_in = 1'b1; opcode_in = 4'hA; mem_read_in = 1'b1; addr_in = 16'hA000;
    @(posedge clk);
    @(negedge clk);
    dmem_resp = 1'b1; dmem_rdata = 16'hB004;
    @(posedge clk);
    @(negedge clk);
    dmem_resp = 1'b0;
    #1;
    check("ind_req", {30'd0, dmem_read, dmem_write}, 32'd2);
    check("ind_addr", {16'd0, dmem_addr}, 32'hB004);
    #1;
    reset_n = 1'b0;
    #1;
    check("rst_ind_req", {30'd0, dmem_read, dmem_write}, 32'd0);
    check("rst_ind_stall", {31'd0, stall_out}, 32'd0);
    check("rst_ind_rdata", {16'd0, mem_rdata_out}, 32'd0);
    valid_in = 1'b0; mem_read_in = 1'b0; opcode_in = 4'h0;
    @(negedge clk);
    reset_n = 1'b1; dmem_resp = 1'b1; dmem_rdata = 16'h5555;
    @(posedge clk);
    @(negedge clk);
    dmem_resp = 1'b0;
    #1;
    check("late_resp_req", {30'd0, dmem_read, dmem_write}, 32'd0);
    check("late_resp_stall", {31'd0, stall_out}, 32'd0);
    check("late_resp_load", {31'd0, load_memwb}, 32'd0);
    check("late_resp_rdata", {16'd0, mem_rdata_out}, 32'd0);
    $display("txn reset-in-IND -> rdata_out=%h", mem_rdata_out);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
